// File: rtl/i2c_target.sv
// Write-only I2C target: ACKs writes to DEVICE_ADDR and strobes each data byte out as wr_valid/wr_addr/wr_data.
// Latency: wr_valid rises SYNC_STAGES+1 clk after the raw SCL rise of a data byte's 8th bit; no backpressure.
// I2C_TARGET_AUTOINC_EN: wr_addr post-increments after every strobe, so burst bytes go to consecutive registers.
module i2c_target #(
  parameter logic [6:0] DEVICE_ADDR = 7'h3C,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl,
  inout  wire        sda,
  output logic       wr_valid,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE, DEV, DEV_ACK, REG, REG_ACK, DATA, DATA_ACK, IGNORE
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_q;
  logic                   sda_q;
  logic [6:0]             shift;
  logic [2:0]             bit_cnt;
  logic                   ack_low;
  logic                   ack_phase;

  logic       scl_s;
  logic       sda_s;
  logic       scl_rise;
  logic       scl_fall;
  logic       start_cond;
  logic       stop_cond;
  logic [7:0] byte_in;
  logic       last_bit;

  assign sda = ack_low ? 1'b0 : 1'bz;

  assign scl_s    = scl_sync[SYNC_STAGES-1];
  assign sda_s    = sda_sync[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_q;
  assign scl_fall = ~scl_s & scl_q;
  // SCL must be high on both samples so a simultaneous SCL/SDA change is never taken as START/STOP.
  assign start_cond = scl_s & scl_q & sda_q & ~sda_s;
  assign stop_cond  = scl_s & scl_q & ~sda_q & sda_s;
  // shift holds the first seven bits; the eighth completes the byte on the same SCL rise.
  assign byte_in  = {shift, sda_s};
  assign last_bit = (bit_cnt == 3'd7);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      scl_sync  <= '1;
      sda_sync  <= '1;
      scl_q     <= 1'b1;
      sda_q     <= 1'b1;
      shift     <= '0;
      bit_cnt   <= '0;
      ack_low   <= 1'b0;
      ack_phase <= 1'b0;
      wr_valid  <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      busy      <= 1'b0;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
      scl_q    <= scl_s;
      sda_q    <= sda_s;
      wr_valid <= 1'b0;
`ifdef I2C_TARGET_AUTOINC_EN
      if (wr_valid) wr_addr <= wr_addr + 8'd1;
`endif
      if (start_cond) begin
        state     <= DEV;
        bit_cnt   <= '0;
        ack_low   <= 1'b0;
        ack_phase <= 1'b0;
        busy      <= 1'b0;
      end else if (stop_cond) begin
        state     <= IDLE;
        bit_cnt   <= '0;
        ack_low   <= 1'b0;
        ack_phase <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state)
          DEV, REG, DATA: begin
            if (scl_rise) begin
              shift   <= byte_in[6:0];
              bit_cnt <= bit_cnt + 3'd1;
              if (last_bit) begin
                if (state == DEV) begin
                  if (byte_in[7:1] == DEVICE_ADDR && !byte_in[0]) begin
                    state <= DEV_ACK;
                    busy  <= 1'b1;
                  end else begin
                    state <= IGNORE;
                  end
                end else if (state == REG) begin
                  wr_addr <= byte_in;
                  state   <= REG_ACK;
                end else begin
                  wr_data  <= byte_in;
                  wr_valid <= 1'b1;
                  state    <= DATA_ACK;
                end
              end
            end
          end
          DEV_ACK, REG_ACK, DATA_ACK: begin
            // First SCL fall after the byte opens the ACK slot, the second closes it.
            if (scl_fall) begin
              if (!ack_phase) begin
                ack_low   <= 1'b1;
                ack_phase <= 1'b1;
              end else begin
                ack_low   <= 1'b0;
                ack_phase <= 1'b0;
                state     <= (state == DEV_ACK) ? REG : DATA;
              end
            end
          end
          IDLE, IGNORE: begin
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: bit-banged open-drain master, queue model of expected register writes.
module tb_i2c_target;

  localparam int SYNC = 2;
  localparam int Q    = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scl = 1'b1;
  logic       m_low = 1'b0;
  logic       ack_ok = 1'b0;
  wire        sda;
  logic       wr_valid;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;

  int checks = 0;
  int fails = 0;
  int cyc = 0;
  int last_rise_cyc = 0;

  logic [15:0] exp_q[$];
  logic [15:0] got[$];

  assign sda = m_low ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_target #(.DEVICE_ADDR(7'h3C), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .reset(reset), .scl(scl), .sda(sda),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_addr(input logic [7:0] r, input int i);
`ifdef I2C_TARGET_AUTOINC_EN
    return r + i[7:0];
`else
    return r;
`endif
  endfunction

  // Compare process: every strobe must match the next queued write and land at the documented latency;
  // the target may only pull SDA low inside an ACK slot the model expects.
  always @(negedge clk) begin
    if (!reset) begin
      if (wr_valid) begin
        got.push_back({wr_addr, wr_data});
        check("strobe_latency", cyc - last_rise_cyc, SYNC + 1);
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_strobe: got %h expected none", {wr_addr, wr_data});
        end else begin
          check("write", {wr_addr, wr_data}, exp_q.pop_front());
        end
      end
      if (!m_low && !ack_ok) check("sda_released", sda, 1);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic start_c();
    m_low = 1'b0; tick(Q);
    scl = 1'b1;   tick(Q);
    m_low = 1'b1; tick(Q);
    scl = 1'b0;   tick(Q);
  endtask

  task automatic stop_c();
    m_low = 1'b1; tick(Q);
    scl = 1'b1;   tick(Q);
    m_low = 1'b0; tick(2 * Q);
  endtask

  task automatic send_bit(input logic b);
    m_low = !b; tick(Q);
    scl = 1'b1; last_rise_cyc = cyc; tick(2 * Q);
    scl = 1'b0; tick(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic exp_ack, output logic ack);
    for (int i = 7; i >= 1; i--) send_bit(b[i]);
    ack_ok = exp_ack;
    send_bit(b[0]);
    m_low = 1'b0; tick(Q);
    scl = 1'b1;   tick(Q);
    ack = sda;    tick(Q);
    scl = 1'b0;   tick(Q);
    ack_ok = 1'b0;
  endtask

  task automatic write_txn(input logic [7:0] dev, input logic [7:0] ra,
                           input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                           input int n);
    logic matched;
    logic a;
    logic [7:0] d;
    matched = (dev[7:1] == 7'h3C) && !dev[0];
    start_c();
    send_byte(dev, matched, a);
    check("ack_dev", a, {31'b0, !matched});
    check("busy_addressed", busy, {31'b0, matched});
    send_byte(ra, matched, a);
    check("ack_reg", a, {31'b0, !matched});
    for (int i = 0; i < n; i++) begin
      d = (i == 0) ? d0 : (i == 1) ? d1 : d2;
      if (matched) exp_q.push_back({exp_addr(ra, i), d});
      send_byte(d, matched, a);
      check("ack_data", a, {31'b0, !matched});
    end
    stop_c();
    check("busy_after_stop", busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic a;
    logic [7:0] dat;
    int n0;

    tick(5);
    check("rst_wr_valid", wr_valid, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_busy", busy, 0);
    check("rst_sda", sda, 1);
    reset = 1'b0;
    tick(5);

    // Single write
    write_txn(8'h78, 8'h12, 8'hA5, 8'h00, 8'h00, 1);
    check("single_count", got.size(), 1);
    if (got.size() >= 1) check("single_pin", got[0], 16'h12A5);

    // Wrong address, then read bit set
    n0 = got.size();
    write_txn(8'h7A, 8'h12, 8'h55, 8'h00, 8'h00, 1);
    write_txn(8'h79, 8'h12, 8'h55, 8'h00, 8'h00, 1);
    check("ignore_no_strobe", got.size(), n0);

    // Burst
    n0 = got.size();
    write_txn(8'h78, 8'hFE, 8'h01, 8'h02, 8'h03, 3);
    check("burst_count", got.size(), n0 + 3);
    if (got.size() == n0 + 3) begin
`ifdef I2C_TARGET_AUTOINC_EN
      check("burst_pin0", got[n0],     16'hFE01);
      check("burst_pin1", got[n0 + 1], 16'hFF02);
      check("burst_pin2", got[n0 + 2], 16'h0003);
`else
      check("burst_pin0", got[n0],     16'hFE01);
      check("burst_pin1", got[n0 + 1], 16'hFE02);
      check("burst_pin2", got[n0 + 2], 16'hFE03);
`endif
    end

    // Repeated START after the REG byte
    n0 = got.size();
    start_c();
    send_byte(8'h78, 1'b1, a); check("rs_ack_dev", a, 0);
    send_byte(8'h12, 1'b1, a); check("rs_ack_reg", a, 0);
    write_txn(8'h78, 8'h40, 8'h5A, 8'h00, 8'h00, 1);
    check("rs_count", got.size(), n0 + 1);
    if (got.size() == n0 + 1) check("rs_pin", got[n0], 16'h405A);

    // Reset during the 5th data bit
    n0 = got.size();
    dat = 8'hC3;
    start_c();
    send_byte(8'h78, 1'b1, a); check("rst_ack_dev", a, 0);
    send_byte(8'h12, 1'b1, a); check("rst_ack_reg", a, 0);
    check("rst_busy_before", busy, 1);
    for (int i = 7; i >= 4; i--) send_bit(dat[i]);
    m_low = !dat[3];
    tick(2);
    reset = 1'b1;
    tick(1);
    check("midrst_sda", sda, {31'b0, !m_low});
    check("midrst_busy", busy, 0);
    check("midrst_wr_valid", wr_valid, 0);
    tick(2);
    reset = 1'b0;
    tick(Q);
    stop_c();
    check("midrst_no_strobe", got.size(), n0);
    write_txn(8'h78, 8'h33, 8'h77, 8'h00, 8'h00, 1);
    check("post_rst_count", got.size(), n0 + 1);
    if (got.size() == n0 + 1) check("post_rst_pin", got[n0], 16'h3377);

    // STOP in the middle of the REG byte
    n0 = got.size();
    start_c();
    send_byte(8'h78, 1'b1, a); check("stop_ack_dev", a, 0);
    check("stop_busy_before", busy, 1);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    stop_c();
    check("stop_busy", busy, 0);
    check("stop_sda", sda, 1);
    check("stop_no_strobe", got.size(), n0);

    tick(10);
    check("pending_writes", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
